// File: rtl/fb_pkg.sv
// Shared constants, slot-state enum and colour-bar table for the VGA framebuffer arbiter.
package fb_pkg;

  localparam int FB_W      = 320;
  localparam int FB_H      = 240;
  localparam int FB_ADDR_W = 17;

  localparam logic [FB_ADDR_W-1:0] FB_DEPTH  = 17'd76800;
  localparam logic [9:0]           H_VISIBLE = 10'd640;
  localparam logic [9:0]           V_VISIBLE = 10'd480;

  typedef enum logic {
    BLANK  = 1'b0,
    ACTIVE = 1'b1
  } slot_e;

  // One stage of the pixel latency pipeline.
  typedef struct packed {
    slot_e slot;
    logic  disp;
  } pipe_t;

  localparam logic [7:0] BAR_COLOURS [8] = '{
    8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00
  };

  function automatic logic [7:0] bar_colour(input logic [2:0] idx);
    return BAR_COLOURS[idx];
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Combinational 2x2-scaled framebuffer address: (vcount>>1)*320 + (hcount>>1),
// built from shifts and adds only.
module fb_addr_gen
  import fb_pkg::*;
(
  input  logic [9:0]           hcount,
  input  logic [9:0]           vcount,
  output logic [FB_ADDR_W-1:0] addr
);

  logic [FB_ADDR_W-1:0] row;
  logic [FB_ADDR_W-1:0] col;

  always_comb begin
    row  = {7'd0, vcount} >> 1;
    col  = {7'd0, hcount} >> 1;
    addr = (row << 8) + (row << 6) + col;
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display fetch owns even active cycles, one writer
// gets every other cycle. Optional colour-bar test pattern under FB_TEST_PATTERN_EN.
module vga_fb_arbiter
  import fb_pkg::*;
(
  input  logic                 clk_25mhz,
  input  logic                 reset_n,
`ifdef FB_TEST_PATTERN_EN
  input  logic                 test_mode,
`endif
  input  logic [9:0]           hcount,
  input  logic [9:0]           vcount,
  input  logic                 wr_valid,
  input  logic [FB_ADDR_W-1:0] wr_addr,
  input  logic [7:0]           wr_data,
  output logic                 wr_ready,
  output logic                 wr_oob,
  output logic [FB_ADDR_W-1:0] mem_addr,
  output logic                 mem_we,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  output logic [7:0]           pixel,
  output logic                 pixel_valid
);

  logic [FB_ADDR_W-1:0] disp_addr;
  slot_e                slot_d;
  logic                 tm;
  logic                 disp_slot;
  logic                 accept;
  logic                 in_range;

  logic [FB_ADDR_W-1:0] mem_addr_d, mem_addr_q;
  logic                 mem_we_d, mem_we_q;
  logic [7:0]           mem_wdata_d, mem_wdata_q;
  logic                 wr_oob_d, wr_oob_q;
  logic [7:0]           pixel_d, pixel_q;
  logic                 pixel_valid_d, pixel_valid_q;
  pipe_t                st1_d, st1_q;
  pipe_t                st2_d, st2_q;

`ifdef FB_TEST_PATTERN_EN
  logic [2:0] bar1_d, bar1_q, bar2_d, bar2_q;
  logic       tm1_d, tm1_q, tm2_d, tm2_q;
`endif

  fb_addr_gen u_addr_gen (
    .hcount (hcount),
    .vcount (vcount),
    .addr   (disp_addr)
  );

  // Handshake: a write transfers on any cycle where wr_valid && wr_ready;
  // wr_ready is purely combinational from the current slot and the writer
  // must hold wr_valid/wr_addr/wr_data stable until that happens.
  always_comb begin
`ifdef FB_TEST_PATTERN_EN
    tm = test_mode;
`else
    tm = 1'b0;
`endif
    slot_d    = ((hcount >= H_VISIBLE) || (vcount >= V_VISIBLE)) ? BLANK : ACTIVE;
    disp_slot = (slot_d == ACTIVE) && !hcount[0] && !tm;
    wr_ready  = reset_n && !disp_slot;
    accept    = wr_valid && wr_ready;
    in_range  = (wr_addr < FB_DEPTH);

    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    wr_oob_d    = 1'b0;
    if (disp_slot) begin
      mem_addr_d = disp_addr;
    end else if (accept) begin
      if (in_range) begin
        mem_addr_d  = wr_addr;
        mem_we_d    = 1'b1;
        mem_wdata_d = wr_data;
      end else begin
        wr_oob_d = 1'b1;
      end
    end

    st1_d.slot = slot_d;
    st1_d.disp = disp_slot;
    st2_d      = st1_q;

`ifdef FB_TEST_PATTERN_EN
    bar1_d = hcount[9:7];
    bar2_d = bar1_q;
    tm1_d  = tm;
    tm2_d  = tm1_q;
`endif

    // Odd columns carry no read of their own; they repeat the even column's pixel.
    pixel_valid_d = (st2_q.slot == ACTIVE);
    pixel_d       = 8'h00;
    if (pixel_valid_d) begin
`ifdef FB_TEST_PATTERN_EN
      if (tm2_q) pixel_d = bar_colour(bar2_q);
      else
`endif
      if (st2_q.disp) pixel_d = mem_rdata;
      else            pixel_d = pixel_q;
    end
  end

  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
      wr_oob_q      <= 1'b0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
      st1_q         <= '{slot: BLANK, disp: 1'b0};
      st2_q         <= '{slot: BLANK, disp: 1'b0};
`ifdef FB_TEST_PATTERN_EN
      bar1_q        <= '0;
      bar2_q        <= '0;
      tm1_q         <= 1'b0;
      tm2_q         <= 1'b0;
`endif
    end else begin
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      wr_oob_q      <= wr_oob_d;
      pixel_q       <= pixel_d;
      pixel_valid_q <= pixel_valid_d;
      st1_q         <= st1_d;
      st2_q         <= st2_d;
`ifdef FB_TEST_PATTERN_EN
      bar1_q        <= bar1_d;
      bar2_q        <= bar2_d;
      tm1_q         <= tm1_d;
      tm2_q         <= tm2_d;
`endif
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;
  assign wr_oob      = wr_oob_q;
  assign pixel       = pixel_q;
  assign pixel_valid = pixel_valid_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: directed coordinates and writes, a synchronous
// RAM model, and a monitor comparing per-cycle expectations at fixed latencies.
module tb_vga_fb_arbiter;

  logic        clk_25mhz = 1'b0;
  logic        reset_n   = 1'b0;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        wr_valid;
  logic [16:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        wr_oob;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  pixel;
  logic        pixel_valid;

  vga_fb_arbiter dut (
    .clk_25mhz   (clk_25mhz),
    .reset_n     (reset_n),
`ifdef FB_TEST_PATTERN_EN
    .test_mode   (1'b0),
`endif
    .hcount      (hcount),
    .vcount      (vcount),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .wr_oob      (wr_oob),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .pixel       (pixel),
    .pixel_valid (pixel_valid)
  );

  // ---------------- clock / cycle counter ----------------
  always #20 clk_25mhz = ~clk_25mhz;

  int cyc = 0;
  always @(posedge clk_25mhz) cyc <= cyc + 1;

  // ---------------- RAM model ----------------
  logic [7:0] ram       [0:76799];
  bit         ram_valid [0:76799];

  function automatic logic [7:0] pat(input int a);
    logic [31:0] t;
    t = a * 37 + (a >> 8) + 11;
    return t[7:0];
  endfunction

  always @(posedge clk_25mhz) begin
    if (int'(mem_addr) < 76800) begin
      mem_rdata <= ram_valid[mem_addr] ? ram[mem_addr] : pat(int'(mem_addr));
      if (mem_we) begin
        ram[mem_addr]       <= mem_wdata;
        ram_valid[mem_addr] <= 1'b1;
      end
    end else begin
      mem_rdata <= 8'h00;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] cyc;
    logic        rdy;
  } rdy_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic        we;
    logic        oob;
    logic [16:0] addr;
    logic [7:0]  wdata;
  } mem_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic        pv;
    logic [7:0]  pix;
  } pix_t;

  rdy_t rdy_q[$];
  mem_t mem_q[$];
  pix_t pix_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic stale(input string name);
    checks++;
    errors++;
    $display("FAIL %s cyc=%0d expectation never presented", name, cyc);
  endtask

  logic [7:0]  shadow [0:76799];
  logic        pend;
  logic [16:0] pend_addr;
  logic [7:0]  pend_data;
  logic        stream;
  logic [16:0] last_addr;
  logic [7:0]  last_wdata;
  logic        cnt_en;
  int          acc_vis;
  int          acc_blk;

  function automatic int exp_addr(input int h, input int v);
    return (v / 2) * 320 + (h / 2);
  endfunction

  // ---------------- driver ----------------
  task automatic step(input int h, input int v);
    logic active, disp, rdy, acc;
    rdy_t r;
    mem_t m;
    pix_t p;
    hcount   = 10'(h);
    vcount   = 10'(v);
    wr_valid = pend;
    wr_addr  = pend_addr;
    wr_data  = pend_data;
    active   = (h < 640) && (v < 480);
    disp     = active && (h % 2 == 0);
    rdy      = !disp;
    acc      = pend && rdy;

    r.cyc = 32'(cyc);
    r.rdy = rdy;
    rdy_q.push_back(r);

    p.cyc = 32'(cyc);
    p.pv  = active;
    p.pix = active ? shadow[exp_addr(h, v)] : 8'h00;
    pix_q.push_back(p);

    m.cyc   = 32'(cyc);
    m.we    = 1'b0;
    m.oob   = 1'b0;
    m.addr  = last_addr;
    m.wdata = last_wdata;
    if (disp) begin
      m.addr = 17'(exp_addr(h, v));
    end else if (acc) begin
      if (int'(pend_addr) < 76800) begin
        m.we    = 1'b1;
        m.addr  = pend_addr;
        m.wdata = pend_data;
        shadow[pend_addr] = pend_data;
      end else begin
        m.oob = 1'b1;
      end
    end
    last_addr  = m.addr;
    last_wdata = m.wdata;
    mem_q.push_back(m);

    if (acc) begin
      if (stream) begin
        pend_addr = pend_addr + 17'd1;
        pend_data = pend_data + 8'd1;
      end else begin
        pend = 1'b0;
      end
    end
    @(posedge clk_25mhz);
    #1;
  endtask

  task automatic set_write(input logic [16:0] a, input logic [7:0] d);
    pend      = 1'b1;
    pend_addr = a;
    pend_data = d;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk_25mhz) begin
    if (!reset_n) begin
      chk("rst_mem_addr",    32'(mem_addr),    32'd0);
      chk("rst_mem_we",      32'(mem_we),      32'd0);
      chk("rst_mem_wdata",   32'(mem_wdata),   32'd0);
      chk("rst_pixel",       32'(pixel),       32'd0);
      chk("rst_pixel_valid", 32'(pixel_valid), 32'd0);
      chk("rst_wr_oob",      32'(wr_oob),      32'd0);
      chk("rst_wr_ready",    32'(wr_ready),    32'd0);
    end else begin
      while (rdy_q.size() > 0 && int'(rdy_q[0].cyc) < cyc) begin
        void'(rdy_q.pop_front());
        stale("wr_ready_stale");
      end
      if (rdy_q.size() > 0 && int'(rdy_q[0].cyc) == cyc) begin
        rdy_t r;
        r = rdy_q.pop_front();
        chk("wr_ready", 32'(wr_ready), 32'(r.rdy));
      end

      while (mem_q.size() > 0 && int'(mem_q[0].cyc) + 1 < cyc) begin
        void'(mem_q.pop_front());
        stale("mem_stale");
      end
      if (mem_q.size() > 0 && int'(mem_q[0].cyc) + 1 == cyc) begin
        mem_t m;
        m = mem_q.pop_front();
        chk("mem_we",    32'(mem_we),    32'(m.we));
        chk("mem_addr",  32'(mem_addr),  32'(m.addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(m.wdata));
        chk("wr_oob",    32'(wr_oob),    32'(m.oob));
      end

      while (pix_q.size() > 0 && int'(pix_q[0].cyc) + 3 < cyc) begin
        void'(pix_q.pop_front());
        stale("pixel_stale");
      end
      if (pix_q.size() > 0 && int'(pix_q[0].cyc) + 3 == cyc) begin
        pix_t p;
        p = pix_q.pop_front();
        chk("pixel_valid", 32'(pixel_valid), 32'(p.pv));
        chk("pixel",       32'(pixel),       32'(p.pix));
      end

      if (cnt_en && wr_valid && wr_ready) begin
        if (int'(hcount) < 640) acc_vis++;
        else                    acc_blk++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    hcount   = 10'd700;
    vcount   = 10'd0;
    wr_valid = 1'b1;
    wr_addr  = 17'd3;
    wr_data  = 8'h00;
    pend     = 1'b0;
    pend_addr = '0;
    pend_data = '0;
    stream   = 1'b0;
    cnt_en   = 1'b0;
    acc_vis  = 0;
    acc_blk  = 0;
    last_addr  = '0;
    last_wdata = '0;
    for (int i = 0; i < 76800; i++) shadow[i] = pat(i);

    repeat (4) @(posedge clk_25mhz);
    #1;
    reset_n = 1'b1;

    // first line after release, then row 1 at column pair 100/101
    for (int h = 0; h < 6; h++) step(h, 0);
    for (int h = 100; h < 104; h++) step(h, 3);

    // writer stalled on an even active column, accepted on the odd one
    set_write(17'd5, 8'hA5);
    for (int h = 200; h < 204; h++) step(h, 3);

    // out-of-range and edge-of-range writes during vertical blank
    set_write(17'd76800, 8'h3C);
    step(10, 490);
    step(11, 490);
    set_write(17'd76799, 8'h77);
    step(12, 490);
    set_write(17'h1FFFF, 8'h11);
    step(13, 490);
    step(14, 490);

    // continuous writer across one full line
    stream = 1'b1;
    set_write(17'd50000, 8'h00);
    cnt_en = 1'b1;
    for (int h = 0; h < 800; h++) step(h, 20);
    cnt_en = 1'b0;
    stream = 1'b0;
    pend   = 1'b0;

    // line and frame wrap
    step(798, 524);
    step(799, 524);
    for (int h = 0; h < 4; h++) step(h, 0);

    // reset asserted right after a write is accepted
    set_write(17'd1234, 8'h5A);
    step(700, 100);
    shadow[1234] = pat(1234);
    reset_n = 1'b0;
    rdy_q.delete();
    mem_q.delete();
    pix_q.delete();
    last_addr  = '0;
    last_wdata = '0;
    pend       = 1'b0;
    repeat (3) @(posedge clk_25mhz);
    #1;
    reset_n = 1'b1;
    for (int h = 0; h < 4; h++) step(h, 4);
    for (int h = 640; h < 644; h++) step(h, 4);
    repeat (4) @(posedge clk_25mhz);
    #1;

    chk("line_accepts_visible", 32'(acc_vis), 32'd320);
    chk("line_accepts_blank",   32'(acc_blk), 32'd160);
    chk("rst_dropped_write",    32'(ram_valid[1234]), 32'd0);
    chk("write5_landed",        32'(ram_valid[5]), 32'd1);
    chk("write5_data",          32'(ram[5]), 32'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
